// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, padder state type and padding helpers
//
// Shared by the block padder and the hash core.
//   SHA256_PAD_WORD    : marker word that follows the last message word
//   SHA256_BLOCK_WORDS : 32-bit words per 512-bit block
//   sha256_num_blocks  : padded block count for an N-word message
//   sha256_pad_word    : value of global word g of the padded message
package sha256_pkg;

  localparam logic [31:0] SHA256_PAD_WORD    = 32'h80000000;
  localparam int          SHA256_BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    PAD_IDLE,
    PAD_FETCH,
    PAD_OFFER,
    PAD_FINISH
  } pad_state_e;

  // ceil((n+3)/16): message words, one marker word and two length words.
  function automatic int sha256_num_blocks(input int n);
    return (n + 18) / 16;
  endfunction

  // Word 14 of the last block is the upper length half; messages are at
  // most 4000 words, so it is always zero and falls into the default arm.
  function automatic logic [31:0] sha256_pad_word(
    input logic [31:0] g,
    input logic [31:0] n,
    input logic        last,
    input logic [3:0]  k,
    input logic [31:0] rd
  );
    if (g < n) begin
      return rd;
    end else if (g == n) begin
      return SHA256_PAD_WORD;
    end else if (last && (k == 4'd15)) begin
      return {n[26:0], 5'b0};
    end else begin
      return 32'h0;
    end
  endfunction

endpackage

// File: rtl/sha256_block_padder.sv
// rtl/sha256_block_padder.sv - reads a message from memory and offers padded SHA-256 blocks
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, message_addr   : begin a message at word address message_addr (IDLE only)
//   busy, done            : busy from start until done; done pulses once per message
//   mem_clk, mem_we       : memory clock (= clk), write enable (always 0)
//   mem_addr              : read address, 0 outside FETCH
//   mem_read_data         : read data, one cycle after the address
//   blk_valid, blk_ready  : block handshake
//   blk_data              : word k of the block in bits [32k+31:32k]
//   blk_last, blk_index   : final-block flag and block number of the offered block
module sha256_block_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         busy,
  output logic         done,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic [7:0]   blk_index
);

  localparam logic [7:0]  LAST_BLK  = 8'(sha256_num_blocks(NUM_OF_WORDS) - 1);
  localparam logic [31:0] MSG_WORDS = 32'(NUM_OF_WORDS);

  pad_state_e  state_q;
  logic [15:0] base_q;
  logic [7:0]  b_q;
  logic [4:0]  c_q;
  logic        busy_q;
  logic        done_q;
  logic        valid_q;
  logic        last_q;
  logic [31:0] buf_q [SHA256_BLOCK_WORDS];

  // Data returning in FETCH cycle c belongs to the address issued at c-1.
  logic [3:0]  k_w;
  logic [31:0] g_w;

  assign k_w = 4'(c_q - 5'd1);
  assign g_w = {20'h0, b_q, k_w};

  assign mem_clk   = clk;
  assign mem_we    = 1'b0;
  assign mem_addr  = (state_q == PAD_FETCH)
                   ? base_q + {4'h0, b_q, 4'h0} + {11'h0, c_q}
                   : 16'h0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign blk_valid = valid_q;
  assign blk_last  = last_q;
  assign blk_index = b_q;

  for (genvar i = 0; i < SHA256_BLOCK_WORDS; i++) begin : g_pack
    assign blk_data[32*i +: 32] = buf_q[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PAD_IDLE;
      base_q  <= 16'h0;
      b_q     <= 8'h0;
      c_q     <= 5'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < SHA256_BLOCK_WORDS; i++) begin
        buf_q[i] <= 32'h0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PAD_IDLE: begin
          if (start) begin
            base_q  <= message_addr;
            b_q     <= 8'h0;
            c_q     <= 5'h0;
            busy_q  <= 1'b1;
            state_q <= PAD_FETCH;
          end
        end
        PAD_FETCH: begin
          if (c_q != 5'd0) begin
            buf_q[k_w] <= sha256_pad_word(g_w, MSG_WORDS, b_q == LAST_BLK, k_w, mem_read_data);
          end
          if (c_q == 5'd16) begin
            valid_q <= 1'b1;
            last_q  <= (b_q == LAST_BLK);
            state_q <= PAD_OFFER;
          end else begin
            c_q <= c_q + 5'd1;
          end
        end
        PAD_OFFER: begin
          if (blk_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= PAD_FINISH;
            end else begin
              b_q     <= b_q + 8'd1;
              c_q     <= 5'h0;
              state_q <= PAD_FETCH;
            end
          end
        end
        PAD_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= PAD_IDLE;
        end
        default: state_q <= PAD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha256_block_padder.md
# sha256_block_padder

Upstream feeder for the SHA-256 hash core. It reads a raw message of NUM_OF_WORDS 32-bit words from testbench memory and applies standard SHA-256 padding: a 0x80000000 marker word, zero fill, and the 64-bit bit-length. It presents each padded 512-bit block to the hash core over a valid/ready handshake. The hash core then needs no memory-read or padding logic of its own.

## Interface
- NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..4000.
- clk  in  1  sole clock; also drives mem_clk.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a message; sampled only in IDLE.
- message_addr  in  16  word address of message word 0; latched on start.
- busy  out  1  high from the start-sampling edge until done.
- done  out  1  one-cycle pulse after the final block handshake.
- mem_clk  out  1  equal to clk.
- mem_we  out  1  constant 0; this block only reads.
- mem_addr  out  16  read address.
- mem_read_data  in  32  memory data, valid one cycle after the address.
- blk_valid  out  1  blk_data holds a complete padded block.
- blk_ready  in  1  the hash core accepts the block.
- blk_data  out  512  word k of the block sits in bits [32k+31:32k].
- blk_last  out  1  the offered block is the final block.
- blk_index  out  8  index of the offered block, starting at 0.

## Operation
- Definitions:
  - N = NUM_OF_WORDS.
  - NB = (N+18)/16, computed at elaboration; this is ceil((N+3)/16).
  - Global word index g = 16*b + k, where b is the block and k the word within it.
- Word value for index g:
  - g < N: mem_read_data.
  - g == N: 32'h80000000.
  - (b == NB-1, k == 14): 32'h0, the upper half of the length.
  - (b == NB-1, k == 15): N*32 as a 32-bit value.
  - All other words: 0.
- FSM states: IDLE, FETCH, OFFER, FINISH.
  - IDLE, start=1: latch message_addr, b←0, c←0, go to FETCH. busy rises.
  - FETCH: counter c runs 0..16.
    - mem_addr = base + 16*b + c, combinational from registers, modulo 2^16.
    - On each edge with c≥1, capture word c-1 into the block buffer.
    - On the edge with c==16, go to OFFER.
    - Addresses are driven even for padding words; that read data is discarded.
  - OFFER: blk_valid=1, and blk_last=(b==NB-1).
    - On an edge with blk_ready=1: if last, go to FINISH; otherwise b←b+1, c←0, go to FETCH.
  - FINISH: done=1 for one cycle, busy←0, go to IDLE.
- mem_addr = 0 outside FETCH.
- start is ignored outside IDLE.
- blk_data and blk_index hold stable while blk_valid=1 and blk_ready=0.
- blk_valid never deasserts without a handshake.
- blk_ready is ignored outside OFFER.
- Reset is asynchronous at any time, including mid-FETCH and mid-OFFER.
  - All state returns to IDLE immediately.
  - The partial block is discarded.
  - No done pulse is produced.

## Timing
- Reset values: busy 0, done 0, mem_we 0, mem_addr 0, blk_valid 0, blk_last 0, blk_index 0, blk_data 0.
- Each block takes 17 FETCH cycles.
- blk_valid is first visible 17 edges after the edge that samples start.
- After a handshake, the next block's blk_valid is visible 17 edges later.
- done is high in the cycle after the last handshake edge. IDLE is re-entered one edge later, and a new start is accepted from then on.
- Minimum total, with blk_ready held at 1: 18*NB + 1 cycles from the start-sampling edge to IDLE.
- Memory read latency is fixed at 1 cycle. A longer latency is unsupported.

## Structure
- Shared package sha256_pkg holds:
  - SHA256_PAD_WORD = 32'h80000000.
  - SHA256_BLOCK_WORDS = 16.
  - Function sha256_num_blocks(N) = (N+18)/16.
  - The padder state enum.
- The hash core imports the same package.
- No sub-module is used. Pad-word selection is a package function, sha256_pad_word(g, N, last, k, rd).
- The block is a single FSM plus a 16×32 buffer, packed into blk_data.

## Test plan
- Two-block message (N=20), words 0x1..0x14 at message_addr 0x0010, blk_ready=1:
  - Block 0 words are 0x1..0x10, blk_last=0, blk_index=0.
  - Block 1 words 0-3 are 0x11..0x14; word 4 is 0x80000000; words 5-14 are 0; word 15 is 0x00000280; blk_last=1.
  - done pulses once.
  - Total time is 37 cycles.
- Single-block boundary (N=13): one block.
  - Word 13 is 0x80000000, word 14 is 0, word 15 is 0x000001A0.
  - blk_last=1, blk_index=0.
- Overflow boundary (N=14): two blocks.
  - Block 0: word 14 is 0x80000000, word 15 is 0.
  - Block 1: words 0-14 are 0, word 15 is 0x000001C0.
- Backpressure (N=20): hold blk_ready=0 for 5 cycles in OFFER of block 0.
  - blk_valid and blk_data stay stable, and mem_addr stays 0.
  - Block 1 blk_valid appears 17 edges after the handshake.
- Reset mid-FETCH: assert reset at c=7 of block 1.
  - All outputs take their reset values in the same cycle, and no done pulse occurs.
  - A following start reproduces the full correct two-block sequence.
- start asserted while busy is ignored.
- message_addr 0xFFFA with N=20: mem_addr wraps 0xFFFF→0x0000 with correct capture.
